// File: rtl/demux_1x2_with_valid_pkg.sv
// Shared types and route constants for the valid-tagged 1:2 demultiplexer.
package demux_1x2_with_valid_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

    localparam logic ROUTE_0 = 1'b0;
    localparam logic ROUTE_1 = 1'b1;

endpackage

// File: rtl/demux_1x2_with_valid_settle_counter.sv
// Blanking counter: loads on a route change and counts down once per input valid.
// It saturates at zero.
module settle_counter #(
    parameter int SETTLE_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [SETTLE_W-1:0] load_val_i,
    input  logic                dec_i,
    output logic                last_o,
    output logic                zero_o
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= load_val_i;
        end else if (dec_i && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last_o = (cnt == SETTLE_W'(1));
    assign zero_o = (cnt == '0);

endmodule

// File: rtl/demux_1x2_with_valid.sv
// Registered 1:2 demux for valid-tagged samples, with post-switch blanking of N valid samples.
// Build option DEMUX_HOLD_LAST_EN: the deselected output's data register freezes instead of clearing.
//
// state     | meaning
// ST_RUN    | active route passes data_valid_i through
// ST_SETTLE | route just changed; blanking valid samples until the counter expires
module demux_1x2_with_valid
    import demux_1x2_with_valid_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SETTLE_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sel_i,
    input  logic [SETTLE_W-1:0] settle_i,
    input  logic                data_valid_i,
    input  logic [WIDTH-1:0]    in_i,
    output logic                data_valid0_o,
    output logic [WIDTH-1:0]    out0_o,
    output logic                data_valid1_o,
    output logic [WIDTH-1:0]    out1_o,
    output logic                busy_o
);

    state_e state;
    logic   active;
    logic   switch_edge;
    logic   cnt_last;
    logic   cnt_zero;

    assign switch_edge = (sel_i != active);

    settle_counter #(
        .SETTLE_W(SETTLE_W)
    ) u_settle_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (switch_edge),
        .load_val_i (settle_i),
        .dec_i      ((state == ST_SETTLE) && data_valid_i),
        .last_o     (cnt_last),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_RUN;
            active        <= ROUTE_0;
            data_valid0_o <= 1'b0;
            data_valid1_o <= 1'b0;
        end else if (switch_edge) begin
            // The sample coincident with the switch is dropped uncounted.
            active        <= sel_i;
            data_valid0_o <= 1'b0;
            data_valid1_o <= 1'b0;
            state         <= (settle_i == '0) ? ST_RUN : ST_SETTLE;
        end else if (state == ST_RUN) begin
            data_valid0_o <= data_valid_i && (active == ROUTE_0);
            data_valid1_o <= data_valid_i && (active == ROUTE_1);
        end else begin
            data_valid0_o <= 1'b0;
            data_valid1_o <= 1'b0;
            if (cnt_zero || (data_valid_i && cnt_last)) begin
                state <= ST_RUN;
            end
        end
    end

    // Data follows sel_i directly: on a switch edge sel_i is already the new route.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out0_o <= '0;
            out1_o <= '0;
        end else begin
            if (sel_i == ROUTE_0) begin
                out0_o <= in_i;
`ifndef DEMUX_HOLD_LAST_EN
            end else begin
                out0_o <= '0;
`endif
            end
            if (sel_i == ROUTE_1) begin
                out1_o <= in_i;
`ifndef DEMUX_HOLD_LAST_EN
            end else begin
                out1_o <= '0;
`endif
            end
        end
    end

    assign busy_o = (state == ST_SETTLE);

endmodule

// File: tb/tb_demux_1x2_with_valid.sv
// Self-checking bench for demux_1x2_with_valid against a route/blank-count reference model.
module tb_demux_1x2_with_valid;

    logic        clk;
    logic        rst_ni;
    logic        sel;
    logic [7:0]  settle;
    logic        dv;
    logic [15:0] din;
    logic        v0, v1, busy;
    logic [15:0] o0, o1;

    int total = 0;
    int bad   = 0;

    // Reference model: current route, valid samples still to blank, expected outputs.
    logic        m_active;
    int          m_blank;
    logic        m_v0, m_v1;
    logic [15:0] m_o0, m_o1;

    demux_1x2_with_valid #(.WIDTH(16), .SETTLE_W(8)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .sel_i         (sel),
        .settle_i      (settle),
        .data_valid_i  (dv),
        .in_i          (din),
        .data_valid0_o (v0),
        .out0_o        (o0),
        .data_valid1_o (v1),
        .out1_o        (o1),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] act_vec();
        return {v0, o0, v1, o1, busy};
    endfunction

    function automatic logic [34:0] exp_vec();
        return {m_v0, m_o0, m_v1, m_o1, (m_blank > 0)};
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_blank  = 0;
        m_v0 = 1'b0; m_v1 = 1'b0;
        m_o0 = '0;   m_o1 = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, return 1 ns after it.
    task automatic step(input logic s, input logic [7:0] st, input logic v, input logic [15:0] d);
        @(negedge clk);
        sel = s; settle = st; dv = v; din = d;
        @(posedge clk);
        if (s != m_active) begin
            m_active = s;
            m_blank  = st;
            m_v0 = 1'b0; m_v1 = 1'b0;
        end else if (m_blank > 0) begin
            m_v0 = 1'b0; m_v1 = 1'b0;
            if (v) m_blank = m_blank - 1;
        end else begin
            m_v0 = v && (s == 1'b0);
            m_v1 = v && (s == 1'b1);
        end
`ifdef DEMUX_HOLD_LAST_EN
        if (s == 1'b0) m_o0 = d; else m_o1 = d;
`else
        m_o0 = (s == 1'b0) ? d : 16'h0;
        m_o1 = (s == 1'b1) ? d : 16'h0;
`endif
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        sel = 1'b0; settle = '0; dv = 1'b0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (act_vec() !== 35'h0) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", act_vec(), 35'h0);
        end
    endtask

    task automatic test_passthrough();
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 8'd0, 1'b1, 16'(i));
            total++;
            if (v0 !== 1'b1 || o0 !== 16'(i) || v1 !== 1'b0) begin
                bad++;
                $display("FAIL passthrough[%0d]: got v0=%b o0=%h v1=%b want v0=1 o0=%h v1=0",
                         i, v0, o0, v1, 16'(i));
            end
        end
    endtask

    task automatic test_switch_settle();
        logic [4:0] exp_v1;
        logic [4:0] exp_busy;
        exp_v1   = 5'b10000;
        exp_busy = 5'b00111;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 8'd3, 1'b1, 16'h0100 + 16'(k));
            total++;
            if (v1 !== exp_v1[k] || busy !== exp_busy[k] || v0 !== 1'b0 ||
                act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL switch_settle[%0d]: got v1=%b busy=%b vec=%h want v1=%b busy=%b vec=%h",
                         k, v1, busy, act_vec(), exp_v1[k], exp_busy[k], exp_vec());
            end
        end
        total++;
        if (o1 !== 16'h0104) begin
            bad++;
            $display("FAIL switch_fifth_sample: got %h want %h", o1, 16'h0104);
        end
    endtask

    task automatic test_reswitch();
        int vcount;
        step(1'b0, 8'd0, 1'b0, 16'h0);
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            logic s;
            s = (c == 0) ? 1'b1 : ((c < 5) ? 1'b1 : 1'b0);
            // Setting settle=7 after the reload shows it is ignored mid-blanking.
            step(s, (c == 6) ? 8'd7 : 8'd2, (c % 4) == 0, 16'h2000 + 16'(c));
            if (v0 || v1) vcount++;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reswitch[%0d]: got %h want %h", c, act_vec(), exp_vec());
            end
        end
        // Valids land at c=16 only: c=0 dropped, c=4 counted, c=5 reload, c=8/12 blanked.
        total++;
        if (vcount !== 1) begin
            bad++;
            $display("FAIL reswitch_valid_count: got %0d want 1", vcount);
        end
    endtask

    task automatic test_hold_last();
        logic [15:0] want;
        step(1'b0, 8'd0, 1'b1, 16'h1234);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'd0, 1'b1, 16'hA000 + 16'(k));
`ifdef DEMUX_HOLD_LAST_EN
            want = 16'h1234;
`else
            want = 16'h0000;
`endif
            total++;
            if (o0 !== want || o1 !== 16'hA000 + 16'(k)) begin
                bad++;
                $display("FAIL hold_last[%0d]: got o0=%h o1=%h want o0=%h o1=%h",
                         k, o0, o1, want, 16'hA000 + 16'(k));
            end
        end
    endtask

    task automatic test_reset_mid_settle();
        step(1'b0, 8'd5, 1'b1, 16'h0033);
        step(1'b0, 8'd5, 1'b1, 16'h0044);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_settle_busy: got %b want 1", busy);
        end
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if (act_vec() !== 35'h0) begin
            bad++;
            $display("FAIL reset_async: got %h want %h", act_vec(), 35'h0);
        end
        sel = 1'b0; settle = '0; dv = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        step(1'b0, 8'd0, 1'b1, 16'hBEEF);
        total++;
        if (v0 !== 1'b1 || o0 !== 16'hBEEF || v1 !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_route: got v0=%b o0=%h v1=%b busy=%b want v0=1 o0=beef v1=0 busy=0",
                     v0, o0, v1, busy);
        end
    endtask

    task automatic test_random();
        int n_dut, n_mod, n_err;
        logic s;
        n_dut = 0; n_mod = 0; n_err = 0;
        s = m_active;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) s = ~s;
            step(s, 8'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 16'($urandom));
            n_dut += int'(v0) + int'(v1);
            n_mod += int'(m_v0) + int'(m_v1);
            total++;
            if ((v0 & v1) !== 1'b0 || act_vec() !== exp_vec()) begin
                bad++;
                n_err++;
                if (n_err <= 10)
                    $display("FAIL random[%0d]: got %h want %h", c, act_vec(), exp_vec());
            end
        end
        total++;
        if (n_dut !== n_mod) begin
            bad++;
            $display("FAIL random_valid_count: got %0d want %0d", n_dut, n_mod);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_switch_settle();
        test_reswitch();
        test_hold_last();
        test_reset_mid_settle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
